// File: rtl/cal_num_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cal_num_pkg
// Description : Shared types and default widths for the calculation-quantity
//               job sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package cal_num_pkg;

  // Default operand and quantity field widths
  localparam int DATA_WIDTH = 16;
  localparam int QTY_WIDTH  = 4;

  // Sequencer states, explicit 2-bit encoding
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } cal_state_e;

endpackage : cal_num_pkg
`default_nettype wire

// File: rtl/cal_num_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cal_num_seq_ctrl
// Description : Job sequencer. A quantity write starts a job that accepts that
//               many operands, sums them and offers one result beat through a
//               valid/ready handshake. Writes while busy are ignored and flag a
//               sticky overrun error.
// Revision    : 1.0 - initial release
// ============================================================================
module cal_num_seq_ctrl
  import cal_num_pkg::*;
#(
  parameter int DATA_WIDTH = cal_num_pkg::DATA_WIDTH,
  parameter int QTY_WIDTH  = cal_num_pkg::QTY_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [QTY_WIDTH-1:0]            cfg_quantity,
  input  logic                            cfg_quantity_wr,
  input  logic                            err_clr,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [DATA_WIDTH+QTY_WIDTH-1:0] res_data,
  output logic [QTY_WIDTH-1:0]            res_count,
  output logic                            busy,
  output logic                            done,
  output logic                            ovr_err
);

  localparam int SUM_WIDTH = DATA_WIDTH + QTY_WIDTH;

  cal_state_e             r_state;
  cal_state_e             w_state_nxt;
  logic [QTY_WIDTH-1:0]   r_qty;
  logic [QTY_WIDTH-1:0]   w_qty_nxt;
  logic [QTY_WIDTH-1:0]   r_cnt;
  logic [QTY_WIDTH-1:0]   w_cnt_nxt;
  logic [SUM_WIDTH-1:0]   r_sum;
  logic [SUM_WIDTH-1:0]   w_sum_nxt;
  logic                   r_busy;
  logic                   r_res_valid;
  logic                   r_done;
  logic                   r_ovr_err;
  logic                   w_accept;
  logic                   w_handshake;

  // Operand acceptance is a pure decode of state so it never waits on in_valid
  assign in_ready    = (r_state == ACCUM);
  assign w_accept    = in_valid && in_ready;
  assign w_handshake = (r_state == RESULT) && res_ready;

  // State, counter and accumulator registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_qty   <= '0;
      r_cnt   <= '0;
      r_sum   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_qty   <= w_qty_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sum   <= w_sum_nxt;
    end
  end

  // Next-state and datapath decode
  always_comb begin
    w_state_nxt = r_state;
    w_qty_nxt   = r_qty;
    w_cnt_nxt   = r_cnt;
    w_sum_nxt   = r_sum;
    case (r_state)
      IDLE: begin
        if (cfg_quantity_wr) begin
          w_qty_nxt   = cfg_quantity;
          w_cnt_nxt   = '0;
          w_sum_nxt   = '0;
          // An empty job goes straight to presenting a zero result
          w_state_nxt = (cfg_quantity == '0) ? RESULT : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_sum_nxt = r_sum + {{QTY_WIDTH{1'b0}}, in_data};
          w_cnt_nxt = r_cnt + QTY_WIDTH'(1);
          if (r_cnt == (r_qty - QTY_WIDTH'(1))) begin
            w_state_nxt = RESULT;
          end
        end
      end
      RESULT: begin
        if (res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Registered status outputs, derived from the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy      <= 1'b0;
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt != IDLE);
      r_res_valid <= (w_state_nxt == RESULT);
      r_done      <= w_handshake;
    end
  end

  // Sticky overrun flag; a new overrun in the clearing cycle keeps it set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovr_err <= 1'b0;
    end else if (cfg_quantity_wr && (r_state != IDLE)) begin
      r_ovr_err <= 1'b1;
    end else if (err_clr) begin
      r_ovr_err <= 1'b0;
    end
  end

  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_data  = r_sum;
  assign res_count = r_qty;
  assign done      = r_done;
  assign ovr_err   = r_ovr_err;

endmodule : cal_num_seq_ctrl
`default_nettype wire

// File: tb/tb_cal_num_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_cal_num_seq_ctrl
// Description : Directed self-checking bench for cal_num_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cal_num_seq_ctrl;

  localparam int DW = 16;
  localparam int QW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [QW-1:0] cfg_quantity;
  logic          cfg_quantity_wr;
  logic          err_clr;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          res_valid;
  logic          res_ready;
  logic [DW+QW-1:0] res_data;
  logic [QW-1:0] res_count;
  logic          busy;
  logic          done;
  logic          ovr_err;

  int tests = 0;
  int fails = 0;

  cal_num_seq_ctrl #(.DATA_WIDTH(DW), .QTY_WIDTH(QW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_quantity(cfg_quantity), .cfg_quantity_wr(cfg_quantity_wr),
    .err_clr(err_clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_count(res_count),
    .busy(busy), .done(done), .ovr_err(ovr_err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [QW-1:0] q);
    cfg_quantity    = q;
    cfg_quantity_wr = 1'b1;
    step();
    cfg_quantity_wr = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
  endtask

  initial begin
    int accepted;
    int cycles;
    rst_n = 1'b0; cfg_quantity = '0; cfg_quantity_wr = 1'b0; err_clr = 1'b0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
    #2;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_res_data", 32'(res_data), 0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Basic job: 1+2+3
    start_job(4'd3);
    check("basic_busy", 32'(busy), 1);
    check("basic_in_ready", 32'(in_ready), 1);
    check("basic_no_res", 32'(res_valid), 0);
    in_valid = 1'b1;
    in_data = 16'h0001; step();
    in_data = 16'h0002; step();
    in_data = 16'h0003; step();
    in_valid = 1'b0;
    check("basic_res_valid", 32'(res_valid), 1);
    check("basic_in_ready_off", 32'(in_ready), 0);
    check("basic_res_data", 32'(res_data), 32'h6);
    check("basic_res_count", 32'(res_count), 3);
    handshake();
    check("basic_done", 32'(done), 1);
    check("basic_idle", 32'(busy), 0);
    check("basic_res_drop", 32'(res_valid), 0);
    step();
    check("basic_done_pulse", 32'(done), 0);

    // Maximum job with random valid gaps and result backpressure
    start_job(4'd15);
    accepted = 0;
    cycles = 0;
    in_data = 16'hFFFF;
    while (accepted < 15 && cycles < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      if (in_valid && in_ready) accepted++;
      step();
      cycles++;
    end
    in_valid = 1'b1;   // offered but must not be taken while the result waits
    check("max_accepted", 32'(accepted), 15);
    for (int i = 0; i < 5; i++) begin
      check("max_hold_valid", 32'(res_valid), 1);
      check("max_hold_data", 32'(res_data), 32'hEFFF1);
      check("max_no_accept", 32'(in_ready), 0);
      step();
    end
    in_valid = 1'b0;
    check("max_res_count", 32'(res_count), 15);
    handshake();
    check("max_done", 32'(done), 1);

    // Zero quantity
    start_job(4'd0);
    check("zero_res_valid", 32'(res_valid), 1);
    check("zero_res_data", 32'(res_data), 0);
    check("zero_res_count", 32'(res_count), 0);
    check("zero_in_ready", 32'(in_ready), 0);
    handshake();
    check("zero_done", 32'(done), 1);

    // Overrun: write during ACCUM is ignored but flagged
    start_job(4'd4);
    send(16'h0001);
    send(16'h0002);
    cfg_quantity = 4'd9; cfg_quantity_wr = 1'b1;
    step();
    cfg_quantity_wr = 1'b0;
    check("ovr_set", 32'(ovr_err), 1);
    check("ovr_still_accum", 32'(in_ready), 1);
    send(16'h0003);
    send(16'h0004);
    check("ovr_res_valid", 32'(res_valid), 1);
    check("ovr_res_data", 32'(res_data), 32'hA);
    check("ovr_res_count", 32'(res_count), 4);
    // Set and clear together: set wins
    cfg_quantity_wr = 1'b1; err_clr = 1'b1;
    step();
    cfg_quantity_wr = 1'b0; err_clr = 1'b0;
    check("ovr_set_wins", 32'(ovr_err), 1);
    check("ovr_result_kept", 32'(res_count), 4);
    handshake();
    check("ovr_sticky", 32'(ovr_err), 1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovr_cleared", 32'(ovr_err), 0);

    // Reset mid-job
    start_job(4'd5);
    send(16'h0007);
    send(16'h0008);
    rst_n = 1'b0;
    #1;
    check("mrst_in_ready", 32'(in_ready), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_res_data", 32'(res_data), 0);
    check("mrst_res_count", 32'(res_count), 0);
    check("mrst_res_valid", 32'(res_valid), 0);
    step();
    rst_n = 1'b1;
    step();
    start_job(4'd2);
    send(16'h0010);
    send(16'h0020);
    check("mrst_job_data", 32'(res_data), 32'h30);
    check("mrst_job_count", 32'(res_count), 2);
    handshake();

    // Back-to-back: new write in the done cycle
    start_job(4'd1);
    send(16'h0100);
    check("b2b_first_data", 32'(res_data), 32'h100);
    handshake();
    check("b2b_done", 32'(done), 1);
    start_job(4'd2);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_no_ovr", 32'(ovr_err), 0);
    send(16'h0005);
    send(16'h0006);
    check("b2b_second_data", 32'(res_data), 32'hB);
    handshake();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cal_num_seq_ctrl
`default_nettype wire

// File: doc/cal_num_seq_ctrl.md
# cal_num_seq_ctrl

Job sequencer driven by the calculation-quantity register. A write of the quantity field starts a job. The block then accepts exactly that many operands from an input stream, accumulates their sum, and presents one result beat with a valid/ready handshake. It sits between the register block (consuming the quantity value and its one-cycle write strobe) and the VT100 datapath operand source and result sink.

## Interface
Parameters:
- DATA_WIDTH, 16, operand width
- QTY_WIDTH, 4, quantity field width (max job size 2^QTY_WIDTH-1)

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_quantity  in  QTY_WIDTH  quantity field value from register
- cfg_quantity_wr  in  1  one-cycle pulse, registered copy of a register write
- err_clr  in  1  clears sticky error
- in_valid  in  1  operand valid
- in_ready  out  1  operand accept
- in_data  in  DATA_WIDTH  operand
- res_valid  out  1  result valid
- res_ready  in  1  result accept
- res_data  out  DATA_WIDTH+QTY_WIDTH  accumulated sum
- res_count  out  QTY_WIDTH  operands summed (equals latched quantity)
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle pulse after result handshake
- ovr_err  out  1  sticky: quantity write while busy

## Operation
- States: IDLE, ACCUM, RESULT.
- IDLE on cfg_quantity_wr: latch qty = cfg_quantity, clear sum and cnt.
  - qty==0: go to RESULT with sum 0.
  - Otherwise go to ACCUM.
- ACCUM: in_ready=1. Each in_valid&&in_ready adds zero-extended in_data to sum and increments cnt. The accept with cnt==qty-1 moves to RESULT.
- RESULT: res_valid=1, res_data=sum, res_count=qty. On res_ready go to IDLE; done pulses the following cycle.
- cfg_quantity_wr in ACCUM or RESULT: ignored (job continues unchanged), ovr_err set.
- ovr_err: cleared by err_clr. If set and clear occur in the same cycle, set wins.
- Sum width DATA_WIDTH+QTY_WIDTH, so it cannot overflow for a maximum job (15 × 0xFFFF = 0xEFFF1).
- Reset (any time, including mid-job):
  - State returns to IDLE; sum, cnt and qty are cleared.
  - All outputs are 0: in_ready, res_valid, res_data, res_count, busy, done, ovr_err.
  - Any partial job is discarded.

## Timing
- in_ready is a combinational decode of state (no dependency on in_valid). All other outputs are registered.
- Job start: cfg_quantity_wr at cycle T gives busy=1 and in_ready=1 at T+1.
- Zero-quantity job: res_valid=1 at T+1.
- Throughput in ACCUM: one operand per cycle.
- Last operand accepted at cycle K gives res_valid=1 at K+1 and in_ready=0 at K+1.
- res_valid and res_data hold stable until res_ready is sampled high.
- Handshake at cycle R gives, at R+1: done=1, busy=0, res_valid=0.
- A new cfg_quantity_wr at R+1 is accepted (back-to-back jobs). A write at cycle R itself is during busy and sets ovr_err.

## Structure
- Shared package cal_num_pkg holds:
  - state enum cal_state_e {IDLE, ACCUM, RESULT}
  - default widths DATA_WIDTH=16, QTY_WIDTH=4
- Single module; no sub-module required. The FSM, counter and accumulator fit in one file of about 150–200 lines.
- Top-level integration instantiates the quantity register and this block side by side, wiring f_quantity_out → cfg_quantity and f_quantity_wr → cfg_quantity_wr.

## Test plan
- **Basic job:** write qty=3, send 0x0001, 0x0002, 0x0003 with in_valid held high → res_valid one cycle after the 3rd accept, res_data=0x00006, res_count=3; done pulses 1 cycle after res_ready.
- **Maximum job with backpressure:** qty=15, all operands 0xFFFF, with random in_valid gaps; hold res_ready=0 for 5 cycles → res_data=0xEFFF1, stable for all 5 cycles; exactly 15 operands accepted.
- **Zero quantity:** write qty=0 → res_valid=1 the next cycle with res_data=0 and res_count=0; in_ready never asserts.
- **Overrun:** write qty=4 during ACCUM after 2 operands → job completes with 2 more operands (qty stays 2+2=4 accepted), ovr_err=1 and stays set; err_clr pulse → ovr_err=0 the next cycle.
- **Reset mid-job:** assert rst_n low after 2 of 5 operands → all outputs 0 immediately. After release, a qty=2 job with 0x0010, 0x0020 → res_data=0x00030.
- **Back-to-back jobs:** new write the cycle after done → second job starts with sum cleared; no operand of job 1 leaks into job 2's result.
